// File: rtl/mul_arbiter.sv
// mul_arbiter: four requesters share one 16-bit sign-magnitude multiplier.
// A round-robin arbiter picks at most one requester per cycle whenever the
// single-entry result register can take a new result (empty, or being drained
// in the same cycle). Operands are captured at the grant, so requesters may
// drop them right after their handshake. The result appears one cycle after
// the grant and stays stable until the consumer accepts it.

module mul_arbiter #(
  parameter int N    = 32,  // operand/result width; only 32 is supported
  parameter int NREQ = 4    // number of requesters; fixed at 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_id,
  output logic [N-1:0]        rsp_c,
  output logic [3:0]          rsp_flags,
  output logic [15:0]         op_count
);

  // Result of the shared datapath: product word plus {cout, zero, overflow, neg}.
  typedef struct packed {
    logic [N-1:0] c;
    logic [3:0]   flags;
  } mul_res_t;

  // Sign-magnitude multiply on the low half-word of each operand. Bit 15 is
  // the sign, bits 14:0 the magnitude, upper half-word ignored. The zero flag
  // deliberately reflects the operand-A magnitude, not the product.
  function automatic mul_res_t mul_sm(input logic [N-1:0] a, input logic [N-1:0] b);
    mul_res_t   res;
    logic [15:0] p16;
    logic        sign;
    p16       = {1'b0, a[14:0]} * {1'b0, b[14:0]};
    sign      = a[15] ^ b[15];
    res.c     = '0;
    res.c[15] = sign;
    res.c[14:0] = p16[14:0];
    res.flags = {p16[15], (a[14:0] == 15'd0), 1'b0, sign};
    return res;
  endfunction

  // State
  logic [1:0]   ptr_q, ptr_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [1:0]   rsp_id_q, rsp_id_d;
  logic [N-1:0] rsp_c_q, rsp_c_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;
  logic [15:0]  op_count_q, op_count_d;

  // Arbitration / datapath signals
  logic         can_accept_s;
  logic         grant_vld_s;
  logic [1:0]   win_id_s;
  logic [1:0]   scan_idx_s;
  logic [NREQ-1:0] grant_s;
  logic [N-1:0] sel_a_s;
  logic [N-1:0] sel_b_s;
  mul_res_t     mul_res_s;

  // The result register can take a new result if empty or drained this cycle.
  assign can_accept_s = !rsp_valid_q || rsp_ready;

  // Round-robin scan starting at ptr; first asserted request wins. No grant in reset.
  always_comb begin
    grant_vld_s = 1'b0;
    win_id_s    = 2'd0;
    scan_idx_s  = 2'd0;
    if (can_accept_s && !rst) begin
      for (int k = 0; k < 4; k++) begin
        scan_idx_s = ptr_q + 2'(k);
        if (!grant_vld_s && req_valid[scan_idx_s]) begin
          grant_vld_s = 1'b1;
          win_id_s    = scan_idx_s;
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end else begin
      grant_vld_s = 1'b0;
    end
  end

  // One-hot grant toward the requesters.
  always_comb begin
    grant_s = '0;
    if (grant_vld_s) begin
      grant_s[win_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign req_ready = grant_s;

  // Route the winner's operands into the shared multiplier.
  assign sel_a_s   = req_a[win_id_s*N +: N];
  assign sel_b_s   = req_b[win_id_s*N +: N];
  assign mul_res_s = mul_sm(sel_a_s, sel_b_s);

  // Next state: load on grant, drain when consumed without a new grant.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_c_d     = rsp_c_q;
    rsp_flags_d = rsp_flags_q;
    op_count_d  = op_count_q;
    if (grant_vld_s) begin
      ptr_d       = win_id_s + 2'd1;
      rsp_valid_d = 1'b1;
      rsp_id_d    = win_id_s;
      rsp_c_d     = mul_res_s.c;
      rsp_flags_d = mul_res_s.flags;
      op_count_d  = op_count_q + 16'd1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State registers with synchronous reset; pending results are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
      rsp_c_q     <= '0;
      rsp_flags_q <= 4'd0;
      op_count_q  <= 16'd0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_c_q     <= rsp_c_d;
      rsp_flags_q <= rsp_flags_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_flags = rsp_flags_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: scenario tasks with inline checks and
// a scoreboard of expected results filled at grant time, popped on consumption.

module tb_mul_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_c;
  logic [3:0]   rsp_flags;
  logic [15:0]  op_count;

  logic [31:0] a_arr [4];
  logic [31:0] b_arr [4];

  assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

  mul_arbiter #(.N(32), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_flags(rsp_flags), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] c;
    logic [3:0]  f;
  } exp_t;

  exp_t        sb[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          m_ptr = 0;
  logic        m_rv = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  // Reference multiply written with integer arithmetic.
  function automatic exp_t model_mul(input int id, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int unsigned ma, mb, p;
    logic        s;
    ma = a & 32'h7FFF;
    mb = b & 32'h7FFF;
    p  = ma * mb;
    s  = a[15] ^ b[15];
    e.id = 2'(id);
    e.c  = (p & 32'h7FFF) | (s ? 32'h8000 : 32'h0);
    e.f  = {((p >> 15) & 1) == 1, ma == 0, 1'b0, s};
    return e;
  endfunction

  // Reference arbiter: one-hot grant from valid mask, pointer, accept state.
  function automatic logic [3:0] model_grant(input logic [3:0] v, input int p, input logic can);
    logic [3:0] g;
    g = 4'b0000;
    if (can) begin
      for (int k = 3; k >= 0; k--) begin
        if (v[(p + k) % 4]) g = 4'b0001 << ((p + k) % 4);
      end
    end
    return g;
  endfunction

  // Called at the falling edge: consume/compare a response, advance the model, move to next cycle.
  task automatic tick();
    logic [3:0] g;
    exp_t       e;
    if (!rst) begin
      chk_cnt++;
      if (rsp_valid !== m_rv) $display("FAIL rsp_valid_track got %b want %b", rsp_valid, m_rv);
      else pass_cnt++;
    end
    if (!rst && rsp_valid && rsp_ready) begin
      chk_cnt++;
      if (sb.size() == 0) $display("FAIL sb_empty got id=%0d c=%h unexpected response", rsp_id, rsp_c);
      else begin
        e = sb.pop_front();
        if (rsp_id !== e.id || rsp_c !== e.c || rsp_flags !== e.f)
          $display("FAIL sb_result got id=%0d c=%h f=%b want id=%0d c=%h f=%b",
                   rsp_id, rsp_c, rsp_flags, e.id, e.c, e.f);
        else pass_cnt++;
      end
    end
    if (rst) begin
      sb.delete();
      m_ptr = 0; m_rv = 1'b0; m_cnt = 16'd0;
    end else begin
      g = model_grant(req_valid, m_ptr, !m_rv || rsp_ready);
      if (g != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (g[i]) begin
            sb.push_back(model_mul(i, a_arr[i], b_arr[i]));
            m_ptr = (i + 1) % 4;
          end
        end
        m_cnt = m_cnt + 16'd1;
        m_rv  = 1'b1;
      end else if (m_rv && rsp_ready) begin
        m_rv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin a_arr[i] = 32'h1234_0003; b_arr[i] = 32'h0000_0007; end
    repeat (3) begin
      @(negedge clk);
      chk_cnt++;
      if ({rsp_valid, rsp_c, rsp_flags, rsp_id, op_count, req_ready} !== 59'd0)
        $display("FAIL reset_state got v=%b c=%h f=%b id=%0d cnt=%h rdy=%b want all zero",
                 rsp_valid, rsp_c, rsp_flags, rsp_id, op_count, req_ready);
      else pass_cnt++;
      tick();
    end
    rst = 1'b0; req_valid = 4'h0;
  endtask

  // Single op on a given requester; expected values given as constants.
  task automatic test_single(input int id, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ec, input logic [3:0] ef);
    a_arr[id] = a; b_arr[id] = b;
    req_valid = 4'b0001 << id; rsp_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== (4'b0001 << id)) $display("FAIL single_grant got %b want %b", req_ready, 4'b0001 << id);
    else pass_cnt++;
    tick();
    req_valid = 4'h0; a_arr[id] = 32'hDEAD_BEEF; b_arr[id] = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'(id) || rsp_c !== ec || rsp_flags !== ef)
      $display("FAIL single_result got v=%b id=%0d c=%h f=%b want v=1 id=%0d c=%h f=%b",
               rsp_valid, rsp_id, rsp_c, rsp_flags, id, ec, ef);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin a_arr[i] = 32'(i + 1); b_arr[i] = 32'h8000 | 32'(i + 2); end
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp = 4'b0001 << (k % 4);
      chk_cnt++;
      if (req_ready !== exp) $display("FAIL fair_grant%0d got %b want %b", k, req_ready, exp);
      else pass_cnt++;
      chk_cnt++;
      if (op_count !== 16'(k)) $display("FAIL fair_count%0d got %h want %h", k, op_count, 16'(k));
      else pass_cnt++;
      tick();
    end
    req_valid = 4'h0;
    @(negedge clk);
    chk_cnt++;
    if (op_count !== 16'd5) $display("FAIL fair_count_end got %h want 0005", op_count);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    pulse_reset();
    a_arr[0] = 32'd7; b_arr[0] = 32'd3;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    @(negedge clk); tick();
    a_arr[0] = 32'h0000_0001; b_arr[0] = 32'h0000_0001;
    a_arr[1] = 32'h0000_0010; b_arr[1] = 32'h8000_8004;
    a_arr[2] = 32'h0000_0002; b_arr[2] = 32'h0000_0002;
    a_arr[3] = 32'h0000_0003; b_arr[3] = 32'h0000_0003;
    req_valid = 4'hF; rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_c !== 32'h15 ||
          rsp_flags !== 4'b0000 || rsp_id !== 2'd0 || op_count !== 16'd1)
        $display("FAIL bp_hold%0d got rdy=%b v=%b c=%h f=%b id=%0d cnt=%h want rdy=0000 v=1 c=00000015 f=0000 id=0 cnt=0001",
                 k, req_ready, rsp_valid, rsp_c, rsp_flags, rsp_id, op_count);
      else pass_cnt++;
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL bp_release_grant got %b want 0010", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 4'h0;
    @(negedge clk);
    chk_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_c !== 32'h0000_8040 || rsp_flags !== 4'b0001)
      $display("FAIL bp_new_result got v=%b id=%0d c=%h f=%b want v=1 id=1 c=00008040 f=0001",
               rsp_valid, rsp_id, rsp_c, rsp_flags);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    req_valid = 4'hF; rsp_ready = 1'b1;
    @(negedge clk); tick();
    @(negedge clk); tick();
    rsp_ready = 1'b0;
    @(negedge clk); tick();
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL rmid_ready_in_rst got %b want 0000", req_ready);
    else pass_cnt++;
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd0)
      $display("FAIL rmid_cleared got v=%b cnt=%h want v=0 cnt=0000", rsp_valid, op_count);
    else pass_cnt++;
    chk_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL rmid_first_grant got %b want 0001", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 4'h0;
    @(negedge clk); tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    for (int n = 0; n < 300; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin a_arr[i] = $urandom; b_arr[i] = $urandom; end
      if (n % 50 == 7) a_arr[$urandom_range(0, 3)] = 32'hFFFF_8000;
      @(negedge clk);
      exp = model_grant(req_valid, m_ptr, !m_rv || rsp_ready);
      chk_cnt++;
      if (req_ready !== exp) $display("FAIL b2b_grant%0d got %b want %b", n, req_ready, exp);
      else pass_cnt++;
      chk_cnt++;
      if (op_count !== m_cnt) $display("FAIL b2b_count%0d got %h want %h", n, op_count, m_cnt);
      else pass_cnt++;
      tick();
    end
    req_valid = 4'h0; rsp_ready = 1'b1;
    repeat (2) begin @(negedge clk); tick(); end
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL sb_leftover got %0d want 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'h0; rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin a_arr[i] = 32'h0; b_arr[i] = 32'h0; end
    test_reset();
    test_single(0, 32'h0000_0003, 32'h0000_8002, 32'h0000_8006, 4'b0001);
    test_single(1, 32'h0000_4000, 32'h0000_0002, 32'h0000_0000, 4'b1000);
    test_single(2, 32'h0000_8000, 32'h0000_0005, 32'h0000_8000, 4'b0101);
    test_single(3, 32'hFFFF_0005, 32'hABCD_0006, 32'h0000_001E, 4'b0000);
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
